// File: rtl/sqrt_arb_pkg.sv
// Shared types and default sizing for the sqrt arbiter slice.
// Contents: FSM state encoding and the default NREQ / WIDTH / TIMEOUT values.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefWidth   = 32;
  localparam int unsigned DefTimeout = 64;

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Bundle of requester-side and core-side signals around the sqrt arbiter.
//   master : arbiter view (drives gnt/done/result/result_id/err/busy, core_rst/core_a)
//   slave  : requesters plus core view (drives req/a_in, core_rdy/core_sqrt)
interface sqrt_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = $clog2(NREQ)
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic [IDW-1:0]        result_id;
  logic                  err;
  logic                  busy;
  logic                  core_rst;
  logic [WIDTH-1:0]      core_a;
  logic                  core_rdy;
  logic [WIDTH-1:0]      core_sqrt;

  modport master (
    input  req, a_in, core_rdy, core_sqrt,
    output gnt, done, result, result_id, err, busy, core_rst, core_a
  );

  modport slave (
    output req, a_in, core_rdy, core_sqrt,
    input  gnt, done, result, result_id, err, busy, core_rst, core_a
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   rr_ptr_i  : index served last; search starts at rr_ptr_i+1 with wrap
//   any_req_o : at least one request present
//   idx_o     : chosen requester index (0 when any_req_o is low)
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic            any_req_o,
  output logic [IDW-1:0]  idx_o
);

  always_comb begin
    any_req_o = 1'b0;
    idx_o     = '0;
    // Scan from the farthest candidate to the nearest so the nearest one wins.
    for (int unsigned i = NREQ; i >= 1; i--) begin
      if (req_i[IDW'((32'(rr_ptr_i) + i) % NREQ)]) begin
        any_req_o = 1'b1;
        idx_o     = IDW'((32'(rr_ptr_i) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one square-root core among NREQ requesters.
//   clk, rst : clock and synchronous active-high reset
//   bus      : requester side (req, a_in, gnt, done, result, result_id, err, busy)
//              and core side (core_rst, core_a, core_rdy, core_sqrt)
// An operation is launched by holding the core in reset for one cycle with the
// operand on core_a, then releasing it and waiting for core_rdy or a timeout.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DefNreq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic            clk,
  input logic            rst,
  sqrt_arbiter_if.master bus
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   cur_id_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] core_a_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic [WIDTH-1:0] result_q;
  logic [IDW-1:0]   result_id_q;
  logic             err_q;
  logic             busy_q;

  logic             any_req;
  logic [IDW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i     (bus.req),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .idx_o     (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= IDW'(NREQ - 1);
      cur_id_q    <= '0;
      cnt_q       <= '0;
      core_a_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      result_id_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Pulse outputs default low; result fields read 0 outside the done cycle.
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      result_id_q <= '0;
      err_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (any_req) begin
            core_a_q <= bus.a_in[32'(pick_idx) * WIDTH +: WIDTH];
            cur_id_q <= pick_idx;
            gnt_q    <= NREQ'(1) << pick_idx;
            busy_q   <= 1'b1;
            state_q  <= StLaunch;
          end
        end
        StLaunch: begin
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q  <= cnt_q + 1'b1;
          busy_q <= 1'b1;
          // rdy takes precedence over a coincident timeout.
          if (bus.core_rdy) begin
            result_q    <= bus.core_sqrt;
            result_id_q <= cur_id_q;
            done_q      <= NREQ'(1) << cur_id_q;
            state_q     <= StDone;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            result_id_q <= cur_id_q;
            err_q       <= 1'b1;
            done_q      <= NREQ'(1) << cur_id_q;
            state_q     <= StDone;
          end
        end
        StDone: begin
          rr_ptr_q <= cur_id_q;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Core runs only in WAIT; reset forces it quiescent immediately.
  assign bus.core_rst  = rst | (state_q != StWait);
  assign bus.core_a    = core_a_q;
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_id = result_id_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter (NREQ=4, WIDTH=32, TIMEOUT=8) with a
// behavioural square-root core that becomes ready core_lat cycles after reset release.
module tb_sqrt_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt_arbiter_if #(.NREQ(4), .WIDTH(32)) bus ();

  sqrt_arbiter #(
    .NREQ    (4),
    .WIDTH   (32),
    .TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int model_ptr = 3;

  // Core model
  int core_lat   = 5;
  bit core_dead  = 1'b0;
  bit core_stale = 1'b0;
  int core_cyc   = 0;

  function automatic logic [31:0] isqrt(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] c;
    logic [63:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      c = r | (32'd1 << b);
      t = {32'd0, c} * {32'd0, c};
      if (t <= {32'd0, v}) r = c;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.core_rst) core_cyc <= 0;
    else core_cyc <= core_cyc + 1;
  end

  assign bus.core_rdy  = !core_dead && ((core_cyc >= core_lat) || (core_stale && bus.core_rst));
  assign bus.core_sqrt = isqrt(bus.core_a);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 3;
  endtask

  // One isolated operation starting from IDLE; k counts cycles after the sampling edge.
  task automatic run_op(input string name, input logic [3:0] mask, input logic [127:0] ops,
                        input int lat, input bit dead, input bit stale, input int exp_id,
                        input logic [31:0] exp_res, input bit exp_err, input int exp_k);
    int k_done;
    k_done = -1;
    core_lat = lat;
    core_dead = dead;
    core_stale = stale;
    bus.req = mask;
    bus.a_in = ops;
    for (int k = 1; k <= 20 && k_done < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({name, " gnt"}, 64'(bus.gnt), 64'(4'b1 << exp_id));
        check({name, " core_a"}, 64'(bus.core_a), 64'(ops[exp_id*32 +: 32]));
        check({name, " busy"}, 64'(bus.busy), 64'd1);
        bus.req = '0;
        bus.a_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (bus.done != 0) begin
        k_done = k;
        check({name, " done_cycle"}, 64'(k), 64'(exp_k));
        check({name, " done"}, 64'(bus.done), 64'(4'b1 << exp_id));
        check({name, " result"}, 64'(bus.result), 64'(exp_res));
        check({name, " result_id"}, 64'(bus.result_id), 64'(exp_id));
        check({name, " err"}, 64'(bus.err), 64'(exp_err));
      end
    end
    if (k_done < 0) check({name, " done_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    check({name, " idle_busy"}, 64'(bus.busy), 64'd0);
    model_ptr = exp_id;
  endtask

  task automatic wait_gnt(input string name, output logic [3:0] g);
    g = '0;
    for (int n = 0; n < 30 && g == 0; n++) begin
      @(negedge clk);
      g = bus.gnt;
    end
    if (g == 0) check({name, " gnt_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string name, output logic [31:0] res, output logic [1:0] id);
    logic seen;
    seen = 1'b0;
    res = '0;
    id = '0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (bus.done != 0) begin
        seen = 1'b1;
        res = bus.result;
        id = bus.result_id;
      end
    end
    if (!seen) check({name, " done_timeout"}, 64'd0, 64'd1);
  endtask

  typedef struct {
    string        name;
    logic [3:0]   mask;
    logic [127:0] ops;
    int           lat;
    bit           dead;
    int           exp_id;
    logic [31:0]  exp_res;
    bit           exp_err;
    int           exp_k;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [3:0]   g;
    logic [31:0]  res;
    logic [1:0]   id;
    logic [3:0]   mask;
    logic [127:0] ops;
    int           lat;
    bit           dead;
    int           eid;
    int           ndone;

    tbl[0] = '{"single", 4'b0100, {32'd0, 32'h10, 32'd0, 32'd0}, 5, 1'b0, 2, 32'd4, 1'b0, 8};
    tbl[1] = '{"rr_a", 4'b0101, {32'd0, 32'd49, 32'd0, 32'd100}, 3, 1'b0, 0, 32'd10, 1'b0, 6};
    tbl[2] = '{"rr_b", 4'b0101, {32'd0, 32'd49, 32'd0, 32'd100}, 3, 1'b0, 2, 32'd7, 1'b0, 6};
    tbl[3] = '{"max", 4'b1000, {32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0}, 1, 1'b0, 3, 32'hFFFF,
               1'b0, 4};
    tbl[4] = '{"timeout", 4'b0010, {32'd0, 32'd0, 32'd144, 32'd0}, 1, 1'b1, 1, 32'd0, 1'b1, 10};
    tbl[5] = '{"rdy_at_limit", 4'b0001, {32'd0, 32'd0, 32'd0, 32'd64}, 7, 1'b0, 0, 32'd8,
               1'b0, 10};

    bus.a_in = '0;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst gnt", 64'(bus.gnt), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst result", 64'(bus.result), 64'd0);
    check("rst result_id", 64'(bus.result_id), 64'd0);
    check("rst err", 64'(bus.err), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst core_rst", 64'(bus.core_rst), 64'd1);
    check("rst core_a", 64'(bus.core_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle core_rst", 64'(bus.core_rst), 64'd1);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].name, tbl[i].mask, tbl[i].ops, tbl[i].lat, tbl[i].dead, 1'b0,
             tbl[i].exp_id, tbl[i].exp_res, tbl[i].exp_err, tbl[i].exp_k);
    end

    // All four requesting at once from a fresh reset.
    do_reset();
    core_lat = 2;
    core_dead = 1'b0;
    bus.a_in = {32'd16, 32'd9, 32'd4, 32'd1};
    bus.req = 4'b1111;
    for (int op = 0; op < 4; op++) begin
      wait_gnt("all4", g);
      check("all4 gnt", 64'(g), 64'(4'b1 << op));
      bus.req[op] = 1'b0;
      wait_done("all4", res, id);
      check("all4 result_id", 64'(id), 64'(op));
      check("all4 result", 64'(res), 64'(op + 1));
    end

    // Fairness: req[0] held, req[3] arrives during req[0]'s operation.
    bus.req = 4'b0001;
    wait_gnt("fair", g);
    check("fair first", 64'(g), 64'b0001);
    bus.req = 4'b1001;
    wait_done("fair", res, id);
    wait_gnt("fair", g);
    check("fair second", 64'(g), 64'b1000);
    bus.req[3] = 1'b0;
    wait_done("fair", res, id);
    wait_gnt("fair", g);
    check("fair third", 64'(g), 64'b0001);
    bus.req = '0;
    wait_done("fair", res, id);
    @(negedge clk);

    // Stale rdy high during LAUNCH must not complete the operation early.
    run_op("stale", 4'b0100, {32'd0, 32'd81, 32'd0, 32'd0}, 3, 1'b0, 1'b1, 2, 32'd9, 1'b0, 6);
    core_stale = 1'b0;

    // Reset in the middle of WAIT drops the operation.
    core_lat = 5;
    bus.a_in = {32'd0, 32'd0, 32'd25, 32'd0};
    bus.req = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst core_rst", 64'(bus.core_rst), 64'd1);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done != 0) ndone++;
    end
    check("midrst no_done", 64'(ndone), 64'd0);
    bus.a_in = {32'd36, 32'd0, 32'd4, 32'd121};
    bus.req = 4'b1011;
    wait_gnt("midrst", g);
    check("midrst next_gnt", 64'(g), 64'b0001);
    bus.req = '0;
    wait_done("midrst", res, id);
    check("midrst result", 64'(res), 64'd11);
    @(negedge clk);

    // Randomized operations against the round-robin reference model.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      mask = 4'($urandom_range(1, 15));
      ops = {$urandom(), $urandom(), $urandom(), $urandom()};
      lat = $urandom_range(1, 7);
      dead = ($urandom_range(0, 7) == 0);
      eid = -1;
      for (int i = 1; i <= 4; i++) begin
        if (eid < 0 && mask[(model_ptr + i) % 4]) eid = (model_ptr + i) % 4;
      end
      run_op("rand", mask, ops, lat, dead, 1'b0, eid,
             dead ? 32'd0 : isqrt(ops[eid*32 +: 32]), dead, dead ? 10 : 3 + lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one squareroot_f32 core among NREQ requesters using round-robin arbitration.
- Launches each operation by pulsing the core's rst with the operand held on its a input, then waits for core rdy.
- Returns the result to the granted requester with a one-cycle done pulse, and aborts with an error on timeout.
- Sits between the BDPU lane issue logic and the single instantiated sqrt core.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 32, operand and result width; must match the core.
- TIMEOUT, 64, maximum WAIT cycles before abort (>=2).
- IDW, $clog2(NREQ), requester index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester request level.
- a_in  in  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot, one-cycle pulse when that requester's operand is latched.
- done  out  NREQ  one-hot, one-cycle pulse when the result is valid.
- result  out  WIDTH  sqrt result; valid only while done is nonzero, else 0.
- result_id  out  IDW  index of the completing requester, valid with done.
- err  out  1  timeout flag, valid with done.
- busy  out  1  high in every state other than IDLE.
- core_rst  out  1  drives the core's rst.
- core_a  out  WIDTH  drives the core's a; held stable from LAUNCH through WAIT.
- core_rdy  in  1  core rdy.
- core_sqrt  in  WIDTH  core sqrt.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Values while rst is high:
  - state = IDLE, rr_ptr = NREQ-1 (requester 0 has first priority).
  - gnt, done, result, result_id, err, busy all 0.
  - core_a register = 0; core_rst = 1 (core held in reset).
- All outputs are registered except core_rst, which is decoded from state, OR'ed with rst.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - core_rst = 1, keeping the core quiescent.
  - If any req bit is set, pick the first set bit searching from (rr_ptr+1) mod NREQ upward with wrap.
  - Latch that requester's operand into core_a and the index into cur_id. Pulse gnt[cur_id] in the next cycle. Go to LAUNCH.
  - If no req bit is set, stay in IDLE.
- LAUNCH:
  - Exactly one cycle. core_rst = 1, core_a = operand, counter cleared.
  - core_rdy is ignored. Go to WAIT.
- WAIT:
  - core_rst = 0; counter increments each cycle.
  - If core_rdy = 1: capture core_sqrt, set err = 0, go to DONE.
  - Else if counter == TIMEOUT-1: set captured result = 0, err = 1, go to DONE.
  - If rdy and timeout occur in the same cycle, rdy wins (err = 0).
- DONE:
  - Exactly one cycle. done[cur_id] = 1, result, result_id and err valid.
  - rr_ptr is updated to cur_id. core_rst = 1. Go to IDLE.
- Latency: req sampled in IDLE at cycle T; gnt at T+1; LAUNCH at T+1; WAIT from T+2; done one cycle after the first WAIT cycle with core_rdy = 1.
  - With a core needing L cycles after reset release, done appears at T+3+L.
- Minimum spacing between consecutive operations is 4 cycles (IDLE, LAUNCH, WAIT, DONE).
- req is a level signal. A requester deasserts req after seeing gnt; a req still high after done is treated as a new request.
- Changes to req or a_in after the operand is latched have no effect on the current operation.
- Simultaneous requests: exactly one is granted; the others wait in round-robin order. No requester is starved; worst-case wait is NREQ-1 operations.
- Reset mid-operation: the operation is dropped, no done is issued, and the core is held in reset.

Decomposition:
- Package sqrt_arb_pkg: FSM state enum (2-bit); default WIDTH, NREQ and TIMEOUT constants.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any_req, grant index.
  - Unit-tested independently.
- Counter, FSM and operand/result registers live in sqrt_arbiter.

Test Plan:
- Single request: req[2] = 1, a = 0x00000010, core model rdy 5 cycles after reset release -> gnt[2] at T+1; core_a = 0x10; done[2] at T+8; result = 4; result_id = 2; err = 0.
- All four requesting after reset, operands 1, 4, 9, 16, req held until gnt -> grant order 0, 1, 2, 3; results 1, 2, 3, 4, each tagged with the correct result_id.
- Fairness: req[0] held high continuously with req[3] pulsed once -> req[3] is served immediately after the in-flight req[0] operation; req[0] is never granted twice in a row while req[3] is pending.
- Timeout: core model never asserts rdy, TIMEOUT = 8 -> done pulses 8 cycles after WAIT entry with err = 1 and result = 0; FSM returns to IDLE.
- Stale rdy: core model holds rdy = 1 during LAUNCH -> ignored; completion occurs only on rdy seen in WAIT.
- Reset mid-WAIT: rst pulsed for 1 cycle -> no done; busy = 0; core_rst = 1; the next request is granted to requester 0 first.
